// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide sequencer:
// funct encodings, FSM state enum, default datapath width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

    // MFHI/MTHI/MFLO/MTLO (0x10-0x13) and MULT/MULTU/DIV/DIVU (0x18-0x1B)
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

    // MULT/MULTU/DIV/DIVU only
    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift/add multiply (right-shifting {acc,lo}) and
// restoring divide (left-shifting {acc,lo}). Operands arrive as magnitudes;
// sign handling lives in the sequencer. After WIDTH steps:
//   multiply: {res_hi,res_lo} = product,  divide: res_lo = quotient, res_hi = remainder.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    // One load or one multiply/divide step per cycle
    always_comb begin
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // Remainder stays below the divisor, so the difference fits in WIDTH bits
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        if (load) begin
            acc_d  = '0;
            lo_d   = a_mag;
            opnd_d = b_mag;
        end else if (step) begin
            if (mode_div) begin
                acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], div_ge};
            end else begin
                acc_d = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

    assign res_hi = acc_q;
    assign res_lo = lo_q;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage HI/LO unit: accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO,
// runs an iterative multiply or restoring divide, owns HI/LO and stalls
// later HI/LO instructions while busy.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiplier,
// multiply goes IDLE -> FIXUP directly).
module ex_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [5:0]       ex_funct,
    input  logic [WIDTH-1:0] ex_op_a,
    input  logic [WIDTH-1:0] ex_op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             div_q, div_d;
    logic             done_q, done_d;

    logic             hilo_op, accept, core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0] quot, rem;

    assign busy    = (state_q != S_IDLE);
    assign hilo_op = ex_valid & is_hilo_funct(ex_funct);
    assign accept  = hilo_op & ~busy & ~flush;
    assign stall   = hilo_op & busy & ~flush;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

    assign core_load = accept & is_muldiv_funct(ex_funct);

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .mode_div (div_q),
        .a_mag    (mag_w(ex_op_a, ~ex_funct[0])),
        .b_mag    (mag_w(ex_op_b, ~ex_funct[0])),
        .res_hi   (core_hi),
        .res_lo   (core_lo)
    );

    // Sign fixup of the magnitude result from the core (or fast multiplier)
    always_comb begin
        a_neg = sgn_q & a_q[WIDTH-1];
        b_neg = sgn_q & b_q[WIDTH-1];
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = {{WIDTH{1'b0}}, mag_w(a_q, sgn_q)} * {{WIDTH{1'b0}}, mag_w(b_q, sgn_q)};
`else
        prod_mag = {core_hi, core_lo};
`endif
        prod = (a_neg ^ b_neg) ? (~prod_mag + ONE_2W) : prod_mag;
        quot = (a_neg ^ b_neg) ? neg_w(core_lo) : core_lo;
        rem  = a_neg ? neg_w(core_hi) : core_hi;
    end

    // MFHI/MFLO read HI/LO in the accept cycle; zero otherwise
    always_comb begin
        mf_result = '0;
        if (accept && ex_funct == FUNCT_MFHI) mf_result = hi_q;
        if (accept && ex_funct == FUNCT_MFLO) mf_result = lo_q;
    end

    // Sequencer FSM, iteration counter and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        div_d     = div_q;
        done_d    = 1'b0;
        core_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ex_funct == FUNCT_MTHI) hi_d = ex_op_a;
                    if (ex_funct == FUNCT_MTLO) lo_d = ex_op_a;
                    if (is_muldiv_funct(ex_funct)) begin
                        a_d   = ex_op_a;
                        b_d   = ex_op_b;
                        sgn_d = ~ex_funct[0];
                        div_d = ex_funct[1];
                        cnt_d = '0;
                        if (ex_funct[1]) begin
                            state_d = S_DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            state_d = S_FIXUP;
`else
                            state_d = S_MUL;
`endif
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                core_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIXUP: begin
                if (div_q) begin
                    if (b_q == '0) begin
                        // Divide by zero: no trap, fixed result
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush aborts an in-flight op without touching HI/LO
        if (flush && busy) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            core_step = 1'b0;
        end
    end

    // Control and architectural state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: the driver issues instructions and
// pushes expected results from an arithmetic reference model; a monitor pops
// and compares whenever done pulses or an MFHI/MFLO is accepted.
module tb_ex_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int EXP_MUL_BUSY = 1;
`else
    localparam int EXP_MUL_BUSY = W + 1;
`endif
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    logic         clk, reset, ex_valid, flush;
    logic [5:0]   ex_funct;
    logic [W-1:0] ex_op_a, ex_op_b;
    logic         stall, busy, done;
    logic [W-1:0] mf_result, hi, lo;

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_funct(ex_funct),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .mf_result(mf_result),
        .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] exp_done_q[$];
    logic [31:0] exp_mf_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic per MIPS HI/LO rules
    task automatic commit(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        case (f)
            FUNCT_MTHI: m_hi = a;
            FUNCT_MTLO: m_lo = a;
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                if (f == FUNCT_MULT || f == FUNCT_DIV) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'h0, a});
                    sb = longint'({32'h0, b});
                end
                if (f == FUNCT_MULT || f == FUNCT_MULTU) begin
                    p = sa * sb;
                    {m_hi, m_lo} = p;
                end else if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                exp_done_q.push_back({m_hi, m_lo});
            end
            default: ;
        endcase
    endtask

    // Present one instruction in EX and hold it until accepted; returns stall cycles
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        ex_valid = 1'b1;
        ex_funct = f;
        ex_op_a  = a;
        ex_op_b  = b;
        stalls   = 0;
        if (f == FUNCT_MFHI) exp_mf_q.push_back(m_hi);
        if (f == FUNCT_MFLO) exp_mf_q.push_back(m_lo);
        while (1) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 200) begin
                chk("stall_timeout", 64'(stalls), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_funct = 6'h00;
    endtask

    task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int s;
        issue(f, a, b, s);
        commit(f, a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 200) begin
                chk("idle_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT output events against the scoreboard
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL done_unexpected: got done=1 hi=%h lo=%h expected no done", hi, lo);
                    end else begin
                        e = exp_done_q.pop_front();
                        chk("done_hi", 64'(hi), 64'(e[63:32]));
                        chk("done_lo", 64'(lo), 64'(e[31:0]));
                    end
                end
                if (ex_valid && !flush && !stall &&
                    (ex_funct == FUNCT_MFHI || ex_funct == FUNCT_MFLO)) begin
                    if (exp_mf_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL mf_unexpected: got mf_result=%h expected no MF", mf_result);
                    end else begin
                        chk("mf_result", 64'(mf_result), 64'(exp_mf_q.pop_front()));
                    end
                end
            end
        end
    end

    logic [5:0] funct_tab [9] = '{FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                                  FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_ADD};

    initial begin
        int s, nb;
        logic [31:0] ra, rb;
        logic [5:0]  rf;
        reset = 1'b0; ex_valid = 1'b0; ex_funct = '0; ex_op_a = '0; ex_op_b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_stall", 64'(stall), 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_mf", 64'(mf_result), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // MULT 7 * -3: busy duration and exact result
        issue(FUNCT_MULT, 32'd7, 32'hFFFF_FFFD, s);
        commit(FUNCT_MULT, 32'd7, 32'hFFFF_FFFD);
        chk("mult_no_stall_on_accept", 64'(s), 0);
        nb = 0;
        while (1) begin
            @(negedge clk);
            if (!busy || nb > 100) break;
            nb++;
        end
        chk("mult_busy_cycles", 64'(nb), 64'(EXP_MUL_BUSY));
        chk("mult_done_after_busy", 64'(done), 1);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk);
        #1;

        // Divide corner cases
        run(FUNCT_DIVU, 32'd100, 32'd7);
        wait_idle();
        chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        run(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        run(FUNCT_DIVU, 32'd5, 32'd0);
        wait_idle();
        run(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});

        // MULT 3*4, MFLO presented in cycle 1 stalls until busy drops
        run(FUNCT_MULT, 32'd3, 32'd4);
        issue(FUNCT_MFLO, 32'd0, 32'd0, s);
        chk("mflo_stall_cycles", 64'(s), 64'(EXP_MUL_BUSY));

        // MTHI then MFHI next cycle
        run(FUNCT_MTHI, 32'hDEAD_BEEF, 32'd0);
        run(FUNCT_MFHI, 32'd0, 32'd0);
        run(FUNCT_MTLO, 32'h1234_5678, 32'd0);

        // DIV flushed in cycle 10; an ADD during busy never stalls
        issue(FUNCT_DIV, 32'd1000, 32'd3, s);
        repeat (3) begin @(posedge clk); #1; end
        ex_valid = 1'b1; ex_funct = FUNCT_ADD;
        @(negedge clk);
        chk("add_no_stall", 64'(stall), 0);
        chk("add_busy", 64'(busy), 1);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_funct = '0;
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", 64'(busy), 0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (40) @(negedge clk);
        chk("flush_hilo_later", {hi, lo}, {m_hi, m_lo});
        @(posedge clk); #1;

        // Reset asserted in cycle 15 of a MULT
        run(FUNCT_MULT, 32'h0001_2345, 32'hFFF0_0001);
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_stall", 64'(stall), 0);
        chk("midrst_hilo", {hi, lo}, 0);
        chk("midrst_mf", 64'(mf_result), 0);
        exp_done_q.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Randomized instruction stream against the model
        for (int i = 0; i < 60; i++) begin
            rf = funct_tab[$urandom_range(8)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: begin ra = $urandom_range(200); rb = $urandom_range(20); end
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run(rf, ra, rb);
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        run(FUNCT_MFHI, 32'd0, 32'd0);
        run(FUNCT_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        chk("final_hilo", {hi, lo}, {m_hi, m_lo});
        chk("done_q_drained", 64'(exp_done_q.size()), 0);
        chk("mf_q_drained", 64'(exp_mf_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
